seven_segment_scan_controller: RTL and testbench
================================================

SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 50000: clocks each digit is lit per scan slot (legal range 1..65535).
REQ-002 SHALL have parameter DEAD_CYCLES, default 500: clocks with all anodes off between slots (legal range 0..65535).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: 1 = display enabled; 0 = all anodes forced off while scanning continues.
REQ-006 SHALL have port load, input, 1: single-cycle request to capture value_in, dp_in and blank_lz.
REQ-007 SHALL have port value_in, input, 16: four BCD/hex nibbles; [3:0] = digit 0 (rightmost).
REQ-008 SHALL have port dp_in, input, 4: per-digit decimal point, active-low (0 = lit).
REQ-009 SHALL have port blank_lz, input, 1: 1 = blank leading zeros.
REQ-010 SHALL have port an, output, 4: anode enables, active-low, one-hot-low or all ones.
REQ-011 SHALL have port digit_code, output, 4: code for the downstream seven-segment decoder; 4'hF = blank.
REQ-012 SHALL have port dp_out, output, 1: decimal point for the lit digit, active-low.
REQ-013 SHALL have port frame_tick, output, 1: one-cycle pulse at each frame boundary.
REQ-014 SHALL have port pending, output, 1: 1 = captured data waiting for the next frame boundary.

Function
REQ-015 SHALL implement a two-state FSM: ON (slot counter 0..REFRESH_CYCLES-1) and DEAD (counter 0..DEAD_CYCLES-1).
REQ-016 SHALL leave ON for DEAD on the cycle the counter reaches REFRESH_CYCLES-1, clearing the counter.
REQ-017 SHALL leave DEAD for ON on the cycle the counter reaches DEAD_CYCLES-1, clearing the counter and incrementing the 2-bit digit index, which wraps from 3 to 0.
REQ-018 SHALL go directly from ON to ON and increment the index when DEAD_CYCLES = 0, so there are no dead cycles.
REQ-019 SHALL treat the index wrap from 3 to 0 as the frame boundary: frame_tick = 1 for that single cycle.
REQ-020 SHALL, on load = 1, capture value_in, dp_in and blank_lz into shadow registers and set pending = 1; a later load before the boundary overwrites the shadow registers (last wins).
REQ-021 SHALL, at the frame boundary with pending = 1, copy shadow to active registers and clear pending; the digit shown in the new frame's slot 0 uses the new data.
REQ-022 SHALL, when load and the frame boundary coincide, transfer the load-cycle inputs directly to the active registers and leave pending = 0.
REQ-023 SHALL keep active data stable within a frame (no tearing).
REQ-024 SHALL blank digit i (i = 3, 2, 1) when active blank_lz = 1 and active nibbles 3 down to i are all zero; digit 0 is never blanked.
REQ-025 SHALL drive digit_code = 4'hF with the anode still asserted for a blanked digit; dp_out still follows that digit's dp bit.
REQ-026 SHALL, in ON with en = 1, drive an[index] = 0 and other anodes 1, with digit_code = active nibble[index] (or 4'hF if blanked) and dp_out = active dp[index].
REQ-027 SHALL, in DEAD or with en = 0, drive an = 4'b1111, digit_code = 4'hF and dp_out = 1.
REQ-028 SHALL register all outputs: they reflect FSM/index state with exactly one clock of latency.
REQ-029 SHALL keep the slot counter at 16 bits, never exceeding its terminal value.

Reset
REQ-030 SHALL, while reset = 1 at a clock edge, set state = ON, counter = 0, index = 0, active and shadow value = 0, active and shadow dp = 4'b1111, blank_lz regs = 0 and pending = 0.
REQ-031 SHALL hold outputs at an = 4'b1111, digit_code = 4'hF, dp_out = 1, frame_tick = 0 and pending = 0 during reset.
REQ-032 SHALL abort any slot and discard pending data on reset asserted mid-operation; the first cycle after reset deasserts begins slot 0 from counter 0.
REQ-033 SHALL ignore load when it is asserted in the same cycle as reset.

Verification (REFRESH_CYCLES = 4, DEAD_CYCLES = 1 unless stated)
REQ-034 SHALL pass: reset, en = 1, load 16'h1234 with dp_in = 4'b1011 -> after the next boundary, an sequence 1110 (4 clk, code 4, dp 1), 1111 (1 clk), 1101 (code 3, dp 1), 1111, 1011 (code 2, dp 0), 1111, 0111 (code 1, dp 1); frame_tick every 20 clk.
REQ-035 SHALL pass: load 16'h0050 with blank_lz = 1 -> digits 3 and 2 show code F with anodes asserted, digit 1 shows 5, digit 0 shows 0; with 16'h0000, only digit 0 shows 0.
REQ-036 SHALL pass: load 16'hAAAA mid-frame and then 16'h5555 two cycles later -> pending = 1 until the boundary; the next frame shows 5 on all digits and pending = 0.
REQ-037 SHALL pass: load asserted on the boundary cycle -> pending never rises and the new value is shown in slot 0 of that frame.
REQ-038 SHALL pass: en = 0 for one full frame -> an = 1111 throughout while frame_tick keeps its 20-clk period; raising en resumes at the current index.
REQ-039 SHALL pass: DEAD_CYCLES = 0 with reset asserted mid-slot 2 -> an never reads 1111 between slots, and after reset deasserts an = 1110 for 4 clk.

Source files
------------

// File: rtl/seven_segment_scan_controller.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_controller
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit is lit for REFRESH_CYCLES clocks. The slots are separated by
// DEAD_CYCLES clocks with every anode off, which suppresses ghosting. New
// display data is captured into shadow registers on `load`. It is promoted to
// the active registers only at a frame boundary, so a frame never mixes old
// and new digits.
//
// Parameters
//   REFRESH_CYCLES : clocks each digit is lit per slot (1..65535)
//   DEAD_CYCLES    : blanking clocks between slots (0..65535, 0 = none)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   en         in   1 = display enabled, 0 = anodes off (scan keeps running)
//   load       in   one-cycle request to capture value_in / dp_in / blank_lz
//   value_in   in   [15:0] four nibbles, [3:0] = rightmost digit 0
//   dp_in      in   [3:0] per-digit decimal point, active-low
//   blank_lz   in   1 = blank leading zeros
//   an         out  [3:0] anode enables, active-low
//   digit_code out  [3:0] nibble for the segment decoder, 4'hF = blank
//   dp_out     out  decimal point of the lit digit, active-low
//   frame_tick out  one-cycle pulse when the digit index wraps 3 -> 0
//   pending    out  1 = captured data waiting for the next frame boundary
// -----------------------------------------------------------------------------
module seven_segment_scan_controller #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int DEAD_CYCLES    = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [3:0]  digit_code,
    output logic        dp_out,
    output logic        frame_tick,
    output logic        pending
);

    localparam logic [0:0] ST_ON   = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    localparam bit          HAS_DEAD  = (DEAD_CYCLES > 0);
    localparam logic [15:0] REF_LAST  = 16'(REFRESH_CYCLES - 1);
    // DEAD is unreachable when DEAD_CYCLES = 0; the value only needs to be legal.
    localparam logic [15:0] DEAD_LAST = HAS_DEAD ? 16'(DEAD_CYCLES - 1) : 16'd0;

    // Scan state
    logic [0:0]  state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [1:0]  idx_q,   idx_d;
    logic        slot_end;
    logic        boundary;

    // Display data: shadow (captured) and active (shown)
    logic [15:0] sh_val_q,  sh_val_d;
    logic [3:0]  sh_dp_q,   sh_dp_d;
    logic        sh_blz_q,  sh_blz_d;
    logic [15:0] act_val_q, act_val_d;
    logic [3:0]  act_dp_q,  act_dp_d;
    logic        act_blz_q, act_blz_d;
    logic        pend_q,    pend_d;

    // Registered outputs
    logic [3:0]  an_q,   an_d;
    logic [3:0]  code_q, code_d;
    logic        dp_q,   dp_d;
    logic        tick_q;

    logic [3:0]  blank_vec;
    logic [3:0]  cur_nib;

    // Slot sequencing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        idx_d    = idx_q;
        slot_end = 1'b0;
        case (state_q)
            ST_ON: begin
                if (cnt_q == REF_LAST) begin
                    cnt_d = 16'd0;
                    if (HAS_DEAD) begin
                        state_d = ST_DEAD;
                    end else begin
                        // No dead time: step straight to the next digit.
                        idx_d    = idx_q + 2'd1;
                        slot_end = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt_q == DEAD_LAST) begin
                    cnt_d    = 16'd0;
                    state_d  = ST_ON;
                    idx_d    = idx_q + 2'd1;
                    slot_end = 1'b1;
                end
            end
        endcase
        boundary = slot_end && (idx_q == 2'd3);
    end

    // Shadow / active data hand-over
    always_comb begin
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        sh_blz_d  = sh_blz_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        act_blz_d = act_blz_q;
        pend_d    = pend_q;
        if (boundary) begin
            if (load) begin
                // Load on the boundary bypasses the shadow entirely.
                act_val_d = value_in;
                act_dp_d  = dp_in;
                act_blz_d = blank_lz;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                act_val_d = sh_val_q;
                act_dp_d  = sh_dp_q;
                act_blz_d = sh_blz_q;
                pend_d    = 1'b0;
            end
        end else if (load) begin
            sh_val_d = value_in;
            sh_dp_d  = dp_in;
            sh_blz_d = blank_lz;
            pend_d   = 1'b1;
        end
    end

    // Leading-zero blanking: a digit blanks only if it and every digit to its
    // left are zero. Digit 0 always shows.
    always_comb begin
        blank_vec[3] = act_blz_q && (act_val_q[15:12] == 4'h0);
        blank_vec[2] = blank_vec[3] && (act_val_q[11:8] == 4'h0);
        blank_vec[1] = blank_vec[2] && (act_val_q[7:4] == 4'h0);
        blank_vec[0] = 1'b0;
    end

    assign cur_nib = act_val_q[{idx_q, 2'b00} +: 4];

    // Output decode from the current state; registered below.
    always_comb begin
        an_d   = 4'b1111;
        code_d = 4'hF;
        dp_d   = 1'b1;
        if ((state_q == ST_ON) && en) begin
            an_d   = ~(4'b0001 << idx_q);
            code_d = blank_vec[idx_q] ? 4'hF : cur_nib;
            dp_d   = act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ON;
            cnt_q     <= 16'd0;
            idx_q     <= 2'd0;
            sh_val_q  <= 16'd0;
            sh_dp_q   <= 4'b1111;
            sh_blz_q  <= 1'b0;
            act_val_q <= 16'd0;
            act_dp_q  <= 4'b1111;
            act_blz_q <= 1'b0;
            pend_q    <= 1'b0;
            an_q      <= 4'b1111;
            code_q    <= 4'hF;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            sh_blz_q  <= sh_blz_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            act_blz_q <= act_blz_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            code_q    <= code_d;
            dp_q      <= dp_d;
            tick_q    <= boundary;
        end
    end

    assign an         = an_q;
    assign digit_code = code_q;
    assign dp_out     = dp_q;
    assign frame_tick = tick_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// -----------------------------------------------------------------------------
// Testbench for seven_segment_scan_controller.
// Two instances share the stimulus: u_d1 (REFRESH=4, DEAD=1) and u_d0
// (REFRESH=4, DEAD=0). The reference model treats a frame as a position
// 0..FRAME-1 and derives slot, lit/dark and boundary arithmetically. The
// driver pushes the expected registered outputs for every clock edge into a
// per-instance queue, and a monitor pops and compares them after each edge.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_controller;

    localparam int R = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] code;
        logic       dp;
        logic       tick;
        logic       pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, en, load, blank_lz;
    logic [15:0] value_in;
    logic [3:0]  dp_in;

    logic [3:0] an1, code1, an0, code0;
    logic       dp1, tick1, pend1, dp0, tick0, pend0;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q1[$];
    exp_t q0[$];

    // Model state, index 0 -> DEAD=1 instance, index 1 -> DEAD=0 instance
    int          m_pos[2];
    logic [15:0] m_act_v[2], m_sh_v[2];
    logic [3:0]  m_act_dp[2], m_sh_dp[2];
    logic        m_act_b[2], m_sh_b[2], m_pend[2];

    always #5 clk = ~clk;

    seven_segment_scan_controller #(.REFRESH_CYCLES(R), .DEAD_CYCLES(1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .an(an1), .digit_code(code1),
        .dp_out(dp1), .frame_tick(tick1), .pending(pend1)
    );

    seven_segment_scan_controller #(.REFRESH_CYCLES(R), .DEAD_CYCLES(0)) u_d0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .an(an0), .digit_code(code0),
        .dp_out(dp0), .frame_tick(tick0), .pending(pend0)
    );

    // Advance model k by one clock edge with the inputs now being driven and
    // return the outputs the DUT must show after that edge.
    task automatic model_step(input int k, input int d, output exp_t e);
        int  period, frame, slot;
        bit  lit, bnd, blank;
        period = R + d;
        frame  = 4 * period;
        e = '{an: 4'b1111, code: 4'hF, dp: 1'b1, tick: 1'b0, pend: 1'b0};
        if (reset) begin
            m_pos[k]    = 0;
            m_act_v[k]  = 16'h0;  m_sh_v[k]  = 16'h0;
            m_act_dp[k] = 4'hF;   m_sh_dp[k] = 4'hF;
            m_act_b[k]  = 1'b0;   m_sh_b[k]  = 1'b0;
            m_pend[k]   = 1'b0;
            return;
        end
        slot = m_pos[k] / period;
        lit  = (m_pos[k] % period) < R;
        if (lit && en) begin
            blank  = (slot > 0) && m_act_b[k] && ((m_act_v[k] >> (4 * slot)) == 16'h0);
            e.an   = 4'b1111;
            e.an[slot] = 1'b0;
            e.code = blank ? 4'hF : 4'((m_act_v[k] >> (4 * slot)) & 16'hF);
            e.dp   = m_act_dp[k][slot];
        end
        bnd    = (m_pos[k] == frame - 1);
        e.tick = bnd;
        if (bnd) begin
            if (load) begin
                m_act_v[k] = value_in; m_act_dp[k] = dp_in; m_act_b[k] = blank_lz;
                m_pend[k]  = 1'b0;
            end else if (m_pend[k]) begin
                m_act_v[k] = m_sh_v[k]; m_act_dp[k] = m_sh_dp[k]; m_act_b[k] = m_sh_b[k];
                m_pend[k]  = 1'b0;
            end
        end else if (load) begin
            m_sh_v[k] = value_in; m_sh_dp[k] = dp_in; m_sh_b[k] = blank_lz;
            m_pend[k] = 1'b1;
        end
        e.pend   = m_pend[k];
        m_pos[k] = (m_pos[k] + 1) % frame;
    endtask

    // One clock: predict, let the edge happen, then release load on the
    // falling edge where the next inputs are set up.
    task automatic cyc();
        exp_t e;
        model_step(0, 1, e); q1.push_back(e);
        model_step(1, 0, e); q0.push_back(e);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        value_in = v; dp_in = d; blank_lz = b; load = 1'b1;
        cyc();
    endtask

    // Monitor: compare after every active edge
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = '{an: an1, code: code1, dp: dp1, tick: tick1, pend: pend1};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL d1_outputs t=%0t got an=%b code=%h dp=%b tick=%b pend=%b required an=%b code=%h dp=%b tick=%b pend=%b",
                             $time, a.an, a.code, a.dp, a.tick, a.pend, e.an, e.code, e.dp, e.tick, e.pend);
                end
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = '{an: an0, code: code0, dp: dp0, tick: tick0, pend: pend0};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL d0_outputs t=%0t got an=%b code=%h dp=%b tick=%b pend=%b required an=%b code=%h dp=%b tick=%b pend=%b",
                             $time, a.an, a.code, a.dp, a.tick, a.pend, e.an, e.code, e.dp, e.tick, e.pend);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        reset = 1'b1; en = 1'b0; load = 1'b0;
        value_in = 16'h0; dp_in = 4'hF; blank_lz = 1'b0;

        // Reset, with a load that must be ignored
        run(2);
        do_load(16'hBEEF, 4'h0, 1'b0);
        reset = 1'b0;
        en    = 1'b1;

        // Basic scan of 1234 with one decimal point lit
        do_load(16'h1234, 4'b1011, 1'b0);
        run(45);

        // Leading-zero blanking
        do_load(16'h0050, 4'hF, 1'b1);
        run(25);
        do_load(16'h0000, 4'hF, 1'b1);
        run(25);

        // Last load before the boundary wins
        run(3);
        do_load(16'hAAAA, 4'hF, 1'b0);
        run(1);
        do_load(16'h5555, 4'hF, 1'b0);
        run(30);

        // Load exactly on the boundary cycle of the DEAD=1 instance
        guard = 0;
        while (m_pos[0] != 4 * (R + 1) - 1 && guard < 100) begin
            cyc(); guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_err++;
            $display("FAIL boundary_search got guard=%0d required <100", guard);
        end
        do_load(16'h9876, 4'b0110, 1'b0);
        run(22);

        // Display disabled for a full frame, then resumed
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 15) != 0);
            reset    = ($urandom_range(0, 99) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 7) == 0) value_in[15:8] = 8'h00;
            load     = ($urandom_range(0, 7) == 0);
            cyc();
        end
        reset = 1'b0; en = 1'b1;
        run(5);

        // Reset mid-slot 2 of the DEAD=0 instance
        guard = 0;
        while (m_pos[1] != 2 * R + 1 && guard < 100) begin
            cyc(); guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_err++;
            $display("FAIL slot2_search got guard=%0d required <100", guard);
        end
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        do_load(16'h4321, 4'b1110, 1'b0);
        run(40);

        // Let the monitor drain, then confirm every prediction was checked
        @(posedge clk);
        #2;
        n_cmp++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain got q1=%0d q0=%0d required 0/0", q1.size(), q0.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
